// File: rtl/mmio_port_bank_pkg.sv
// Shared address-decode helpers for the p18240 memory-mapped switch/LED bank.
package mmio_port_bank_pkg;

    localparam int OFF_W = 4;

    typedef struct packed {
        logic             hit;
        logic [OFF_W-1:0] off;
    } decode_t;

    function automatic logic [OFF_W-1:0] off_status(input int num_ch);
        return OFF_W'(num_ch);
    endfunction

    function automatic logic [OFF_W-1:0] off_irq_en(input int num_ch);
        return OFF_W'(num_ch + 1);
    endfunction

    // The full 16-bit difference is range-checked so that aliases above the bank miss.
    function automatic decode_t decode_addr(input logic [15:0] addr, input logic [15:0] base,
                                            input int num_ch);
        decode_t     d;
        logic [15:0] diff;
        diff  = addr - base;
        d.hit = (addr >= base) && (diff <= 16'(num_ch + 1));
        d.off = diff[OFF_W-1:0];
        return d;
    endfunction

endpackage

// File: rtl/mmio_port_bank_sync_chain.sv
// Multi-flop synchroniser for one asynchronous input channel.
module sync_chain
    import mmio_port_bank_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [SYNC_STAGES];

    // Shift the raw input through the synchroniser flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                stage_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                stage_r[k] <= stage_r[k-1];
            end
        end
    end

    assign q = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/mmio_port_bank.sv
// Switch/LED I/O bank with change-detect status, interrupt mask and irq line,
// sitting beside the datapath on memAddr/MDRout/re_L/we_L.
module mmio_port_bank
    import mmio_port_bank_pkg::*;
#(
    parameter int          NUM_CH      = 2,
    parameter int          WIDTH       = 16,
    parameter logic [15:0] BASE_ADDR   = 16'h2000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [15:0]             memAddr,
    input  logic [WIDTH-1:0]        dataIn,
    input  logic                    re_L,
    input  logic                    we_L,
    input  logic [NUM_CH*WIDTH-1:0] swIn,
    output logic [WIDTH-1:0]        dataOut,
    output logic                    dataOutEn_L,
    output logic [NUM_CH*WIDTH-1:0] ledOut,
    output logic                    irq
);

    localparam logic [OFF_W-1:0] OFF_STATUS = off_status(NUM_CH);
    localparam logic [OFF_W-1:0] OFF_IRQEN  = off_irq_en(NUM_CH);
    localparam logic [3:0]       ARM_DONE   = 4'(SYNC_STAGES + 1);

    decode_t                 dec_s;
    logic                    wr_s;
    logic                    rd_s;
    logic                    armed_s;
    logic [NUM_CH*WIDTH-1:0] sw_sync_s;
    logic [NUM_CH*WIDTH-1:0] prev_r;
    logic [NUM_CH*WIDTH-1:0] led_r;
    logic [NUM_CH-1:0]       status_r;
    logic [NUM_CH-1:0]       irq_en_r;
    logic [NUM_CH-1:0]       change_s;
    logic [NUM_CH-1:0]       ch_sel_s;
    logic [NUM_CH-1:0]       w1c_s;
    logic [3:0]              arm_cnt_r;
    logic                    irq_r;
    logic [WIDTH-1:0]        rd_ch_s;
    logic [WIDTH-1:0]        data_out_s;

    assign dec_s   = decode_addr(memAddr, BASE_ADDR, NUM_CH);
    assign wr_s    = ~we_L & dec_s.hit;
    // A simultaneous read+write still writes but never drives the bus.
    assign rd_s    = ~re_L & we_L & dec_s.hit;
    assign armed_s = (arm_cnt_r == ARM_DONE);
    assign w1c_s   = (wr_s && (dec_s.off == OFF_STATUS)) ? dataIn[NUM_CH-1:0] : {NUM_CH{1'b0}};

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sync_chain #(
            .WIDTH      (WIDTH),
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clock(clock),
            .reset(reset),
            .d    (swIn[i*WIDTH +: WIDTH]),
            .q    (sw_sync_s[i*WIDTH +: WIDTH])
        );
        assign ch_sel_s[i] = (dec_s.off == OFF_W'(i));
        assign change_s[i] = armed_s & (sw_sync_s[i*WIDTH +: WIDTH] != prev_r[i*WIDTH +: WIDTH]);
    end

    // Count out the reset-release settling window so flushed sync edges never set STATUS.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arm_cnt_r <= 4'd0;
        end else if (!armed_s) begin
            arm_cnt_r <= arm_cnt_r + 4'd1;
        end else begin
            arm_cnt_r <= arm_cnt_r;
        end
    end

    // Register file: LED channels, change status (set beats clear), irq mask and irq flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_r   <= {(NUM_CH*WIDTH){1'b0}};
            led_r    <= {(NUM_CH*WIDTH){1'b0}};
            status_r <= {NUM_CH{1'b0}};
            irq_en_r <= {NUM_CH{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            prev_r   <= sw_sync_s;
            status_r <= (status_r & ~w1c_s) | change_s;
            irq_r    <= |(status_r & irq_en_r);
            if (wr_s && (dec_s.off == OFF_IRQEN)) begin
                irq_en_r <= dataIn[NUM_CH-1:0];
            end else begin
                irq_en_r <= irq_en_r;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_s && ch_sel_s[i]) begin
                    led_r[i*WIDTH +: WIDTH] <= dataIn;
                end else begin
                    led_r[i*WIDTH +: WIDTH] <= led_r[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Zero-latency read mux; the bus reads 0 whenever this bank is not driving it.
    always_comb begin
        rd_ch_s    = {WIDTH{1'b0}};
        data_out_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            rd_ch_s = rd_ch_s | ({WIDTH{ch_sel_s[i]}} & sw_sync_s[i*WIDTH +: WIDTH]);
        end
        if (!rd_s) begin
            data_out_s = {WIDTH{1'b0}};
        end else if (dec_s.off < OFF_STATUS) begin
            data_out_s = rd_ch_s;
        end else if (dec_s.off == OFF_STATUS) begin
            data_out_s = {{(WIDTH-NUM_CH){1'b0}}, status_r};
        end else begin
            data_out_s = {{(WIDTH-NUM_CH){1'b0}}, irq_en_r};
        end
    end

    assign dataOut     = data_out_s;
    assign dataOutEn_L = ~rd_s;
    assign ledOut      = led_r;
    assign irq         = irq_r;

endmodule
